// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with arbitrary depth, standard/FWFT read, fill flags, flush
module sync_fifo_flags #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 12,
  parameter int FWFT_MODE  = 0,
  parameter int AF_THRESH  = 10,
  parameter int AE_THRESH  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FIFO_WIDTH-1:0]              data_in,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic                               flush,
  output logic [FIFO_WIDTH-1:0]              data_out,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]        count,
  output logic                               overflow,
  output logic                               underflow
);
  localparam int ADDR_SIZE = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(FIFO_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE:0]   AF_C    = (ADDR_SIZE + 1)'(AF_THRESH);
  localparam logic [ADDR_SIZE:0]   AE_C    = (ADDR_SIZE + 1)'(AE_THRESH);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [ADDR_SIZE:0]    cnt_nxt;
  logic                  rd_acc, wr_acc;
  assign full         = count == DEPTH_C;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign rd_acc       = rd_en && !empty;
  assign wr_acc       = wr_en && (!full || rd_acc);
  // Pointer wrap at the physical depth and fill-count update
  always_comb begin
    wr_nxt  = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    rd_nxt  = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    cnt_nxt = (wr_acc && !rd_acc) ? count + 1'b1 :
              (rd_acc && !wr_acc) ? count - 1'b1 : count;
  end
  // Pointers, count and rejected-request pulses; flush clears state and masks pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_nxt;
      if (rd_acc) rd_ptr <= rd_nxt;
      count     <= cnt_nxt;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end
  // Storage array; not reset
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= data_in;
  end
  generate
    if (FWFT_MODE != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      // Registered read; holds last value when no read is accepted
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else if (rd_acc && !flush) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: scoreboard bench for standard, FWFT and depth-6 FIFO instances
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       wr_s = 0, rd_s = 0, fl_s = 0;
  logic [7:0] din_s = 0, dout_s;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic [4:0] cnt_s;
  logic       wr_f = 0, rd_f = 0, fl_f = 0;
  logic [7:0] din_f = 0, dout_f;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] cnt_f;
  logic       wr_6 = 0, rd_6 = 0, fl_6 = 0;
  logic [7:0] din_6 = 0, dout_6;
  logic       full_6, empty_6, af_6, ae_6, ovf_6, unf_6;
  logic [3:0] cnt_6;
  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(12), .FWFT_MODE(0), .AF_THRESH(10), .AE_THRESH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(din_s), .wr_en(wr_s), .rd_en(rd_s), .flush(fl_s),
    .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(cnt_s), .overflow(ovf_s), .underflow(unf_s));
  sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(12), .FWFT_MODE(1), .AF_THRESH(10), .AE_THRESH(2)) u_fw (
    .clk(clk), .rst_n(rst_n), .data_in(din_f), .wr_en(wr_f), .rd_en(rd_f), .flush(fl_f),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(unf_f));
  sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(6), .FWFT_MODE(0), .AF_THRESH(5), .AE_THRESH(2)) u_d6 (
    .clk(clk), .rst_n(rst_n), .data_in(din_6), .wr_en(wr_6), .rd_en(rd_6), .flush(fl_6),
    .data_out(dout_6), .full(full_6), .empty(empty_6), .almost_full(af_6), .almost_empty(ae_6),
    .count(cnt_6), .overflow(ovf_6), .underflow(unf_6));
  task automatic cyc(input bit six, input logic w, input logic r, input logic [7:0] d);
    int dep, af, n;
    bit ra, wa;
    logic [7:0] ed, od;
    logic [4:0] oc;
    logic oe, ofl, oaf, oae, oov, oun;
    dep = six ? 6 : 12;
    af = six ? 5 : 10;
    ra = r && q.size() > 0;
    wa = w && (q.size() < dep || ra);
    ed = 8'h00;
    if (six) begin wr_6 = w; rd_6 = r; din_6 = d; end
    else begin wr_s = w; rd_s = r; din_s = d; end
    @(posedge clk);
    #1;
    if (ra) ed = q.pop_front();
    if (wa) q.push_back(d);
    n = q.size();
    od  = six ? dout_6 : dout_s;
    oc  = six ? {1'b0, cnt_6} : cnt_s;
    oe  = six ? empty_6 : empty_s;
    ofl = six ? full_6 : full_s;
    oaf = six ? af_6 : af_s;
    oae = six ? ae_6 : ae_s;
    oov = six ? ovf_6 : ovf_s;
    oun = six ? unf_6 : unf_s;
    checks += 7;
    if (oc !== 5'(n)) begin errors++; $display("FAIL count: got %0d expected %0d", oc, n); end
    if (oe !== (n == 0)) begin errors++; $display("FAIL empty: got %b expected %b", oe, n == 0); end
    if (ofl !== (n == dep)) begin errors++; $display("FAIL full: got %b expected %b", ofl, n == dep); end
    if (oaf !== (n >= af)) begin errors++; $display("FAIL almost_full: got %b expected %b", oaf, n >= af); end
    if (oae !== (n <= 2)) begin errors++; $display("FAIL almost_empty: got %b expected %b", oae, n <= 2); end
    if (oov !== (w && !wa)) begin errors++; $display("FAIL overflow: got %b expected %b", oov, w && !wa); end
    if (oun !== (r && !ra)) begin errors++; $display("FAIL underflow: got %b expected %b", oun, r && !ra); end
    if (ra) begin
      checks++;
      if (od !== ed) begin errors++; $display("FAIL data_out: got %h expected %h", od, ed); end
    end
  endtask
  task automatic test_reset();
    #1;
    checks += 10;
    if (empty_s !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty_s); end
    if (ae_s !== 1'b1) begin errors++; $display("FAIL rst_almost_empty: got %b expected 1", ae_s); end
    if (full_s !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full_s); end
    if (af_s !== 1'b0) begin errors++; $display("FAIL rst_almost_full: got %b expected 0", af_s); end
    if (cnt_s !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", cnt_s); end
    if (dout_s !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h expected 00", dout_s); end
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", ovf_s); end
    if (unf_s !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b expected 0", unf_s); end
    if (empty_f !== 1'b1) begin errors++; $display("FAIL rst_fwft_empty: got %b expected 1", empty_f); end
    if (empty_6 !== 1'b1) begin errors++; $display("FAIL rst_d6_empty: got %b expected 1", empty_6); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 8'h00);
  endtask
  task automatic test_fill();
    for (int i = 1; i <= 12; i++) cyc(0, 1, 0, 8'(i));
    cyc(0, 1, 0, 8'hEE);
    cyc(0, 0, 0, 8'h00);
  endtask
  task automatic test_full_rw();
    cyc(0, 1, 1, 8'hAA);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask
  task automatic test_underflow();
    cyc(0, 0, 1, 8'h00);
    cyc(0, 1, 1, 8'h55);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask
  task automatic test_fwft();
    din_f = 8'h3C; wr_f = 1;
    @(posedge clk); #1;
    wr_f = 0;
    checks += 8;
    if (empty_f !== 1'b0) begin errors++; $display("FAIL fwft_empty: got %b expected 0", empty_f); end
    if (dout_f !== 8'h3C) begin errors++; $display("FAIL fwft_data: got %h expected 3c", dout_f); end
    if (cnt_f !== 5'd1) begin errors++; $display("FAIL fwft_count: got %0d expected 1", cnt_f); end
    if (ae_f !== 1'b1) begin errors++; $display("FAIL fwft_almost_empty: got %b expected 1", ae_f); end
    if (af_f !== 1'b0) begin errors++; $display("FAIL fwft_almost_full: got %b expected 0", af_f); end
    if (full_f !== 1'b0) begin errors++; $display("FAIL fwft_full: got %b expected 0", full_f); end
    if (ovf_f !== 1'b0) begin errors++; $display("FAIL fwft_overflow: got %b expected 0", ovf_f); end
    if (unf_f !== 1'b0) begin errors++; $display("FAIL fwft_underflow: got %b expected 0", unf_f); end
    rd_f = 1;
    @(posedge clk); #1;
    rd_f = 0;
    checks++;
    if (empty_f !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b expected 1", empty_f); end
    din_f = 8'hA1; wr_f = 1;
    @(posedge clk); #1;
    din_f = 8'hA2;
    @(posedge clk); #1;
    wr_f = 0;
    checks++;
    if (dout_f !== 8'hA1) begin errors++; $display("FAIL fwft_first: got %h expected a1", dout_f); end
    rd_f = 1;
    @(posedge clk); #1;
    checks++;
    if (dout_f !== 8'hA2) begin errors++; $display("FAIL fwft_second: got %h expected a2", dout_f); end
    @(posedge clk); #1;
    rd_f = 0;
    checks++;
    if (empty_f !== 1'b1) begin errors++; $display("FAIL fwft_drain_empty: got %b expected 1", empty_f); end
  endtask
  task automatic test_wrap_flush();
    logic [7:0] held;
    for (int i = 0; i < 20; i++) cyc(1, 1, (i % 4) != 0, 8'(i + 1));
    for (int k = 0; k < 10 && q.size() > 0; k++) cyc(1, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'(8'h40 + i));
    held = dout_6;
    checks++;
    if (cnt_6 !== 4'd4) begin errors++; $display("FAIL pre_flush_count: got %0d expected 4", cnt_6); end
    fl_6 = 1; wr_6 = 1; din_6 = 8'h99;
    @(posedge clk); #1;
    fl_6 = 0; wr_6 = 0;
    q.delete();
    checks += 4;
    if (cnt_6 !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", cnt_6); end
    if (empty_6 !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty_6); end
    if (ovf_6 !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", ovf_6); end
    if (dout_6 !== held) begin errors++; $display("FAIL flush_hold: got %h expected %h", dout_6, held); end
    cyc(1, 1, 0, 8'h77);
    cyc(1, 0, 1, 8'h00);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_underflow();
    test_fwft();
    test_wrap_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
